// File: rtl/huffman_merge_ctrl_if.sv
// Bundle between the count stage, the Huffman merge controller and the symbol-count sorter.
// Array index k carries the signal numbered k+1 (C[0] is C1, S[5] is S6).
interface huffman_merge_ctrl_if #(
  parameter int CW = 8,
  parameter int HW = 8
);
  logic          start;
  logic [2:0]    num_sym;
  logic [CW-1:0] C [6];
  logic          srt_valid;
  logic [2:0]    srt_num;
  logic [CW-1:0] O [6];
  logic [2:0]    S [6];
  logic          srt_done;
  logic [HW-1:0] HC [6];
  logic [HW-1:0] M [6];
  logic          code_valid;
  logic          busy;

  modport master (
    input  start, num_sym, C, S, srt_done,
    output srt_valid, srt_num, O, HC, M, code_valid, busy
  );

  modport slave (
    output start, num_sym, C, S, srt_done,
    input  srt_valid, srt_num, O, HC, M, code_valid, busy
  );
endinterface

// File: rtl/huffman_merge_ctrl.sv
// Huffman code builder: one LOAD/WAIT/MERGE round per merge (n-1 rounds), sorter restarted each round.
// No backpressure; start is ignored while busy, srt_done is a level sampled from the second WAIT cycle.
module huffman_merge_ctrl #(
  parameter int CW = 8,
  parameter int HW = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  huffman_merge_ctrl_if.master bus
);
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_MERGE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [2:0]    state_q, state_d;
  logic [2:0]    act_q, act_d;
  logic          armed_q, armed_d;
  logic          wait_first_q, wait_first_d;
  logic [CW-1:0] node_q [6];
  logic [CW-1:0] node_d [6];
  logic [2:0]    grp_q [6];
  logic [2:0]    grp_d [6];
  logic [3:0]    len_q [6];
  logic [3:0]    len_d [6];
  logic [HW-1:0] hc_q [6];
  logic [HW-1:0] hc_d [6];
  logic [HW-1:0] m_q [6];
  logic [HW-1:0] m_d [6];
  logic [2:0]    sel_q [6];
  logic [2:0]    sel_d [6];
  logic [CW-1:0] o_q [6];
  logic [CW-1:0] o_d [6];

  logic [2:0]    num_eff;
  logic [2:0]    last;
  logic [2:0]    idx_a;
  logic [2:0]    idx_b;
  logic [2:0]    lo;
  logic [2:0]    hi;
  logic [CW:0]   sum;

  always_comb begin
    state_d      = state_q;
    act_d        = act_q;
    armed_d      = 1'b1;
    wait_first_d = 1'b0;
    for (int i = 0; i < 6; i++) begin
      node_d[i] = node_q[i];
      grp_d[i]  = grp_q[i];
      len_d[i]  = len_q[i];
      hc_d[i]   = hc_q[i];
      m_d[i]    = m_q[i];
      sel_d[i]  = sel_q[i];
    end

    num_eff = (bus.num_sym == 3'd7) ? 3'd6 : bus.num_sym;
    last    = act_q - 3'd1;
    idx_a   = sel_q[last];
    idx_b   = sel_q[act_q - 3'd2];
    lo      = (idx_a < idx_b) ? idx_a : idx_b;
    hi      = (idx_a < idx_b) ? idx_b : idx_a;
    sum     = {1'b0, node_q[idx_a]} + {1'b0, node_q[idx_b]};

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // armed_q blocks a start that coincides with the first edge after reset release
        if (bus.start && armed_q) begin
          for (int i = 0; i < 6; i++) begin
            node_d[i] = bus.C[i];
            grp_d[i]  = 3'(i);
            len_d[i]  = '0;
            hc_d[i]   = '0;
            m_d[i]    = '0;
          end
          act_d   = num_eff;
          state_d = (num_eff < 3'd2) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d      = ST_WAIT;
        wait_first_d = 1'b1;
      end
      ST_WAIT: begin
        if (!wait_first_q && bus.srt_done) begin
          for (int i = 0; i < 6; i++) sel_d[i] = bus.S[i];
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: begin
        // a takes the 1 branch, b the 0 branch; the merged node lands in the lower slot
        for (int i = 0; i < 6; i++) begin
          if (grp_q[i] == idx_a) begin
            hc_d[i]  = hc_q[i] | (HW'(1) << len_q[i]);
            len_d[i] = len_q[i] + 4'd1;
            m_d[i]   = (HW'(1) << (len_q[i] + 4'd1)) - HW'(1);
            grp_d[i] = lo;
          end else if (grp_q[i] == idx_b) begin
            len_d[i] = len_q[i] + 4'd1;
            m_d[i]   = (HW'(1) << (len_q[i] + 4'd1)) - HW'(1);
            grp_d[i] = lo;
          end else if ((hi != last) && (grp_q[i] == last)) begin
            grp_d[i] = hi;
          end
        end
        node_d[lo] = sum[CW] ? CNT_MAX : sum[CW-1:0];
        if (hi != last) node_d[hi] = node_q[last];
        act_d   = last;
        state_d = (last == 3'd1) ? ST_DONE : ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < 6; i++) o_d[i] = (3'(i) < act_d) ? node_d[i] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      act_q        <= '0;
      armed_q      <= 1'b0;
      wait_first_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        node_q[i] <= '0;
        grp_q[i]  <= '0;
        len_q[i]  <= '0;
        hc_q[i]   <= '0;
        m_q[i]    <= '0;
        sel_q[i]  <= '0;
        o_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      armed_q      <= armed_d;
      wait_first_q <= wait_first_d;
      for (int i = 0; i < 6; i++) begin
        node_q[i] <= node_d[i];
        grp_q[i]  <= grp_d[i];
        len_q[i]  <= len_d[i];
        hc_q[i]   <= hc_d[i];
        m_q[i]    <= m_d[i];
        sel_q[i]  <= sel_d[i];
        o_q[i]    <= o_d[i];
      end
    end
  end

  assign bus.srt_valid  = (state_q == ST_LOAD);
  assign bus.srt_num    = act_q;
  assign bus.busy       = (state_q == ST_LOAD) || (state_q == ST_WAIT) || (state_q == ST_MERGE);
  assign bus.code_valid = (state_q == ST_DONE);

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      bus.O[i]  = o_q[i];
      bus.HC[i] = hc_q[i];
      bus.M[i]  = m_q[i];
    end
  end
endmodule

// File: doc/huffman_merge_ctrl.md
# huffman_merge_ctrl

Controller that turns the symbol-count sorter into a full Huffman code builder. It loads up to six symbol counts and repeatedly restarts the sorter on the live node list. After each sort it merges the two smallest nodes and prepends one code bit to every symbol under them, then compacts the list. When one node remains it presents per-symbol codes and masks. It sits between the count stage (which supplies `C1..C6` and `num_sym`) and the sorter, driving the sorter's valid, num and `O1..O6` inputs.

## Interface
Parameters:
- `CW`, 8: count width.
- `HW`, 8: code and mask width.

Ports:
- `clk`  in  1  clock, all state rising-edge.
- `reset`  in  1  asynchronous reset, active-low (0 = reset).
- `start`  in  1  one-cycle pulse; samples `num_sym` and `C1..C6`. Ignored while `busy`.
- `num_sym`  in  3  number of symbols.
- `C1..C6`  in  CW each  initial symbol counts.
- `srt_valid`  out  1  sorter restart pulse.
- `srt_num`  out  3  live node count for the sorter.
- `O1..O6`  out  CW each  live node counts, slot 0..5.
- `S1..S6`  in  3 each  sorter result: slot indices in descending count order, so `S[srt_num]` is the smallest.
- `srt_done`  in  1  sorter result valid (level).
- `HC1..HC6`  out  HW each  symbol codes. Root-side bit is at position len-1.
- `M1..M6`  out  HW each  code masks, (1<<len)-1.
- `code_valid`  out  1  codes final; held until the next accepted `start`.
- `busy`  out  1  high from the cycle after `start` until DONE.

## Operation
- States: IDLE, LOAD, WAIT, MERGE, DONE.
- Reset (`reset`=0, asynchronous) forces IDLE. All outputs are 0, including `srt_num`, `O*`, `HC*`, `M*`, `code_valid` and `busy`. Reset mid-build aborts the build; no partial codes are kept.
- Accepting `start` in IDLE or DONE:
  - Latch counts into node slots 0..5.
  - Set grp[i] = i.
  - Clear all `HC` and `M`, and all len to 0.
  - Set act = `num_sym`.
  - Go to LOAD.
- `num_sym` edge values:
  - 7 is treated as 6.
  - 0 or 1 goes straight to DONE with all codes and masks 0.
  - Slots at index act and above drive `O` = 0.
- LOAD: `srt_valid`=1 for exactly one cycle, `srt_num`=act, then WAIT.
- WAIT: `srt_done` is ignored in the first WAIT cycle (the sorter's stale done). From the second cycle on, `srt_done`=1 moves to MERGE. `S*` are sampled in that same cycle.
- MERGE (one cycle). Let a = `S[act]` (smallest) and b = `S[act-1]` (second smallest). Ties are resolved by sorter order.
  - Every symbol with grp=a: `HC` |= 1<<len, len+1.
  - Every symbol with grp=b: bit stays 0, len+1.
  - `M` = (1<<len)-1 after the update.
  - lo = min(a,b), hi = max(a,b).
  - node[lo] = node[a] + node[b], saturating at 2^CW-1.
  - Symbols in a or b get grp = lo.
  - If hi ≠ act-1: node[hi] = node[act-1], and symbols with grp = act-1 get grp = hi.
  - act = act-1.
  - Next state: DONE if act = 1, else LOAD.
- DONE: `code_valid`=1, `busy`=0. Outputs hold until the next `start` or reset.
- Symbols at index `num_sym` and above keep `HC`=`M`=0.

## Timing
- `start` at cycle t → LOAD at t+1 (`srt_valid` high, `busy` high) → WAIT from t+2.
- `srt_done` seen at cycle w (w ≥ first WAIT cycle + 1) → MERGE at w+1.
- After MERGE: LOAD at w+2, or DONE with `code_valid`=1 at w+2.
- n symbols need exactly n-1 LOAD/WAIT/MERGE rounds.
- `O*` and `srt_num` are registered and stable from LOAD through WAIT.
- A `start` coincident with the reset release is ignored.

## Test plan
- Two symbols: `num_sym`=2, C=10,5, bench sorter returns S1=0, S2=1.
  - Response: one `srt_valid` pulse, then DONE.
  - HC1=0, M1=1; HC2=1, M2=1.
- Three symbols: C=10,20,30.
  - Round 1: S=2,1,0. After MERGE, O1=30, O2=30, `srt_num`=2.
  - Round 2: S=0,1.
  - Result: HC1=0b01, M1=0b11; HC2=0b00, M2=0b11; HC3=1, M3=1.
- Six symbols: C=1,2,4,8,16,32 with a behavioural sorter.
  - Exactly 5 `srt_valid` pulses.
  - Lengths 5,5,4,3,2,1; M1=0x1F, M6=0x01.
  - Codes are prefix-free.
- Degenerate counts: `num_sym`=1 → DONE in one cycle, all HC/M 0, no `srt_valid`. `num_sym`=7 → behaves as 6.
- Handshake robustness:
  - Hold `srt_done` high from the previous round → no early MERGE.
  - Delay `srt_done` by 12 cycles → `O*` stable throughout.
  - `start` while `busy` → ignored.
- Reset: drop `reset` in round 2 of the six-symbol case → all outputs 0 immediately. A new `start` then produces correct codes.
